// File: rtl/memory_stage.sv
// memory_stage: MEM stage with branch resolution and a direct-mapped write-through data cache
//
// Ports:
//   clk                 rising-edge clock
//   rstn                asynchronous reset, active HIGH; clears every valid bit
//   iSig_branch         instruction is a branch
//   iSig_MemWrite       store this cycle
//   iSig_MemRead        load this cycle
//   iALUzero            ALU zero flag
//   iALUresult          byte address for loads/stores, otherwise passed through
//   iregfile_read_data2 store data
//   iread_from_ram      128-bit RAM line at oram_addr_wdata, valid in the same cycle
//   oMemReadData        load data (0 when no load)
//   oALUresult          copy of iALUresult
//   ocacheHit           1 on hit or when there is no memory access
//   oram_addr_wdata     word-aligned RAM address
//   oram_data_wdata     RAM write data
//   oSig_PCSrc          branch taken
module memory_stage #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         iSig_branch,
    input  logic         iSig_MemWrite,
    input  logic         iSig_MemRead,
    input  logic         iALUzero,
    input  logic [31:0]  iALUresult,
    input  logic [31:0]  iregfile_read_data2,
    input  logic [127:0] iread_from_ram,
    output logic [31:0]  oMemReadData,
    output logic [31:0]  oALUresult,
    output logic         ocacheHit,
    output logic [31:0]  oram_addr_wdata,
    output logic [31:0]  oram_data_wdata,
    output logic         oSig_PCSrc
);
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int TAG_W  = 28 - INDEX_BITS;
    localparam int LINE_W = 32 * LINE_WORDS;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_word;
    logic [TAG_W-1:0]      w_tag;
    logic [LINE_W-1:0]     w_line;
    logic                  w_hit;
    logic                  w_load;
    logic                  w_fill;
    logic                  w_store_hit;
    logic                  w_unused_bits;

    assign w_index       = iALUresult[INDEX_BITS+3:4];
    assign w_word        = iALUresult[3:2];
    assign w_tag         = iALUresult[31:INDEX_BITS+4];
    assign w_unused_bits = ^iALUresult[1:0];
    assign w_line        = r_data[w_index];
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // Simultaneous read and write is handled as a store.
    assign w_load        = iSig_MemRead & ~iSig_MemWrite;
    assign w_fill        = w_load & ~w_hit;
    assign w_store_hit   = iSig_MemWrite & w_hit;

    assign oSig_PCSrc      = iSig_branch & iALUzero;
    assign oALUresult      = iALUresult;
    assign oram_addr_wdata = {iALUresult[31:2], 2'b00};
    assign oram_data_wdata = iregfile_read_data2;
    assign ocacheHit       = (iSig_MemRead | iSig_MemWrite) ? w_hit : 1'b1;
    // A miss forwards the RAM word directly so load data is never late.
    assign oMemReadData    = !w_load ? 32'h0 :
                             w_hit   ? w_line[{w_word, 5'b0} +: 32] :
                                       iread_from_ram[{w_word, 5'b0} +: 32];

    // Only valid bits are reset; tag and data contents are don't-care until filled.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_index] <= 1'b1;
            r_tag[w_index]   <= w_tag;
            r_data[w_index]  <= iread_from_ram;
        end else if (w_store_hit) begin
            r_data[w_index][{w_word, 5'b0} +: 32] <= iregfile_read_data2;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage using directed vectors
module tb_memory_stage;
    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         iSig_branch = 1'b0, iSig_MemWrite = 1'b0, iSig_MemRead = 1'b0, iALUzero = 1'b0;
    logic [31:0]  iALUresult = '0, iregfile_read_data2 = '0;
    logic [127:0] iread_from_ram = '0;
    logic [31:0]  oMemReadData, oALUresult, oram_addr_wdata, oram_data_wdata;
    logic         ocacheHit, oSig_PCSrc;

    typedef struct {
        logic [31:0] rd, alu, addr, wd;
        logic        hit, pc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] LINE_A = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] LINE_B = 128'h4444_4444_3333_3333_2222_2222_9999_0000;
    localparam logic [127:0] LINE_C = 128'h3333_3333_7777_7777_6666_6666_5555_5555;

    memory_stage dut (
        .clk(clk), .rstn(rstn),
        .iSig_branch(iSig_branch), .iSig_MemWrite(iSig_MemWrite), .iSig_MemRead(iSig_MemRead),
        .iALUzero(iALUzero), .iALUresult(iALUresult), .iregfile_read_data2(iregfile_read_data2),
        .iread_from_ram(iread_from_ram), .oMemReadData(oMemReadData), .oALUresult(oALUresult),
        .ocacheHit(ocacheHit), .oram_addr_wdata(oram_addr_wdata), .oram_data_wdata(oram_data_wdata),
        .oSig_PCSrc(oSig_PCSrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector just after a rising edge and queue its expected outputs.
    task automatic vec(input logic br, input logic z, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [127:0] ram,
                       input logic [31:0] exp_rd, input logic exp_hit, input logic exp_pc);
        exp_t x;
        @(posedge clk);
        #1;
        iSig_branch = br; iALUzero = z; iSig_MemRead = rd; iSig_MemWrite = wr;
        iALUresult = alu; iregfile_read_data2 = wd; iread_from_ram = ram;
        x.rd = exp_rd; x.alu = alu; x.addr = {alu[31:2], 2'b00}; x.wd = wd;
        x.hit = exp_hit; x.pc = exp_pc;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("oMemReadData", oMemReadData, e.rd);
            chk("oALUresult", oALUresult, e.alu);
            chk("oram_addr_wdata", oram_addr_wdata, e.addr);
            chk("oram_data_wdata", oram_data_wdata, e.wd);
            chk("ocacheHit", {31'b0, ocacheHit}, {31'b0, e.hit});
            chk("oSig_PCSrc", {31'b0, oSig_PCSrc}, {31'b0, e.pc});
        end
    end

    initial begin
        // reset values
        vec(0, 0, 0, 0, 32'h0, 32'h0, '0, 32'h0, 1, 0);
        @(posedge clk); #1 rstn = 1'b0;
        // branch and pass-through
        vec(1, 1, 0, 0, 32'h0, 32'h0, '0, 32'h0, 1, 1);
        vec(1, 0, 0, 0, 32'h0, 32'h0, '0, 32'h0, 1, 0);
        vec(0, 0, 0, 0, 32'h1234_5678, 32'h0, '0, 32'h0, 1, 0);
        // load miss fill, then hits ignoring RAM
        vec(0, 0, 1, 0, 32'h48, 32'h0, LINE_A, 32'hCCCC_CCCC, 0, 0);
        vec(0, 0, 1, 0, 32'h44, 32'h0, '0, 32'hBBBB_BBBB, 1, 0);
        vec(0, 0, 1, 0, 32'h4B, 32'h0, '0, 32'hCCCC_CCCC, 1, 0);
        // store hit updates cached word
        vec(0, 0, 0, 1, 32'h48, 32'h1111_2222, '0, 32'h0, 1, 0);
        vec(0, 0, 1, 0, 32'h48, 32'h0, '0, 32'h1111_2222, 1, 0);
        // store miss does not allocate
        vec(0, 0, 0, 1, 32'h800, 32'h0000_0055, '0, 32'h0, 0, 0);
        vec(0, 0, 0, 1, 32'h800, 32'h0000_0055, '0, 32'h0, 0, 0);
        vec(0, 0, 1, 0, 32'h800, 32'h0, LINE_B, 32'h9999_0000, 0, 0);
        vec(0, 0, 1, 0, 32'h800, 32'h0, '0, 32'h9999_0000, 1, 0);
        // conflict on index 4
        vec(0, 0, 1, 0, 32'h48, 32'h0, '0, 32'h1111_2222, 1, 0);
        vec(0, 0, 1, 0, 32'h448, 32'h0, LINE_C, 32'h7777_7777, 0, 0);
        vec(0, 0, 1, 0, 32'h448, 32'h0, '0, 32'h7777_7777, 1, 0);
        vec(0, 0, 1, 0, 32'h48, 32'h0, LINE_A, 32'hCCCC_CCCC, 0, 0);
        vec(0, 0, 1, 0, 32'h48, 32'h0, '0, 32'hCCCC_CCCC, 1, 0);
        // asynchronous reset mid-cycle: miss is visible before the next edge, no fill during reset
        @(posedge clk); #1 rstn = 1'b1;
        iSig_MemRead = 1'b1; iSig_MemWrite = 1'b0; iALUresult = 32'h48; iread_from_ram = LINE_C;
        e.rd = 32'h7777_7777; e.alu = 32'h48; e.addr = 32'h48; e.wd = iregfile_read_data2; e.hit = 1'b0; e.pc = 1'b0;
        q.push_back(e);
        vec(0, 0, 0, 0, 32'h0, 32'h0, '0, 32'h0, 1, 0);
        @(posedge clk); #1 rstn = 1'b0;
        vec(0, 0, 1, 0, 32'h48, 32'h0, LINE_A, 32'hCCCC_CCCC, 0, 0);
        // read and write together behave as a store
        vec(0, 0, 1, 1, 32'h48, 32'h0000_9999, '0, 32'h0, 1, 0);
        vec(0, 0, 1, 0, 32'h48, 32'h0, '0, 32'h0000_9999, 1, 0);
        vec(0, 0, 1, 1, 32'hC00, 32'h0000_1234, LINE_B, 32'h0, 0, 0);
        vec(0, 0, 1, 0, 32'hC00, 32'h0, LINE_C, 32'h5555_5555, 0, 0);
        vec(0, 0, 0, 0, 32'h0, 32'h0, '0, 32'h0, 1, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
